// File: rtl/ex_stage.sv
// Execute stage: forwards operands from EX/MEM and MEM/WB, runs the 16-bit ALU,
// and registers the result into the EX/MEM bundle with hold and bubble control.
module ex_stage #(
  parameter bit FWD_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        flush,
  input  logic [62:0] idex_in,
  input  logic        wb_en_in,
  input  logic [2:0]  wb_dest_in,
  input  logic [15:0] wb_data_in,
  output logic [37:0] exmem_reg_out,
  output logic        zero_flag,
  output logic [1:0]  fwd_sel_1,
  output logic [1:0]  fwd_sel_2
);

  localparam logic [1:0] SEL_NONE  = 2'b00;
  localparam logic [1:0] SEL_EXMEM = 2'b01;
  localparam logic [1:0] SEL_MEMWB = 2'b10;

  logic [2:0]  src1_s, src2_s, alu_op_s, dest_s;
  logic [15:0] op1_s, op2_s, store_data_s;
  logic        mem_wr_s, wb_en_s, wb_sel_s;

  assign src1_s       = idex_in[62:60];
  assign src2_s       = idex_in[59:57];
  assign alu_op_s     = idex_in[56:54];
  assign op1_s        = idex_in[53:38];
  assign op2_s        = idex_in[37:22];
  assign mem_wr_s     = idex_in[21];
  assign store_data_s = idex_in[20:5];
  assign wb_en_s      = idex_in[4];
  assign dest_s       = idex_in[3:1];
  assign wb_sel_s     = idex_in[0];

  logic [37:0] exmem_q, exmem_d;
  logic        zero_q, zero_d;

  function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
    logic [15:0] r;
    case (op)
      3'd0:    r = a + b;
      3'd1:    r = a - b;
      3'd2:    r = a & b;
      3'd3:    r = a | b;
      3'd4:    r = a ^ b;
      3'd5:    r = a << b[3:0];
      3'd6:    r = a >> b[3:0];
      3'd7:    r = b;
      default: r = 16'h0000;
    endcase
    return r;
  endfunction

  // A load sitting in EX/MEM has no data yet, so only ALU results are eligible.
  logic ex_ok_s;
  logic ex_hit1_s, ex_hit2_s, mw_hit1_s, mw_hit2_s;
  assign ex_ok_s   = exmem_q[4] & ~exmem_q[0];
  assign ex_hit1_s = ex_ok_s & (exmem_q[3:1] == src1_s) & (src1_s != 3'd0);
  assign ex_hit2_s = ex_ok_s & (exmem_q[3:1] == src2_s) & (src2_s != 3'd0);
  assign mw_hit1_s = wb_en_in & (wb_dest_in == src1_s) & (src1_s != 3'd0);
  assign mw_hit2_s = wb_en_in & (wb_dest_in == src2_s) & (src2_s != 3'd0);

  logic [15:0] opa_s, opb_s, sd_s, fwd2_s, res_s;

  // Operand selection; src2 forwarding lands on store_data for stores, op2 otherwise.
  always_comb begin
    fwd_sel_1 = SEL_NONE;
    fwd_sel_2 = SEL_NONE;
    opa_s     = op1_s;
    opb_s     = op2_s;
    sd_s      = store_data_s;
    fwd2_s    = 16'h0000;
    if (FWD_EN) begin
      if (ex_hit1_s) begin
        fwd_sel_1 = SEL_EXMEM;
        opa_s     = exmem_q[36:21];
      end else if (mw_hit1_s) begin
        fwd_sel_1 = SEL_MEMWB;
        opa_s     = wb_data_in;
      end else begin
        opa_s     = op1_s;
      end
      if (ex_hit2_s) begin
        fwd_sel_2 = SEL_EXMEM;
        fwd2_s    = exmem_q[36:21];
      end else if (mw_hit2_s) begin
        fwd_sel_2 = SEL_MEMWB;
        fwd2_s    = wb_data_in;
      end else begin
        fwd2_s    = 16'h0000;
      end
      if (fwd_sel_2 != SEL_NONE) begin
        if (mem_wr_s) begin
          sd_s  = fwd2_s;
        end else begin
          opb_s = fwd2_s;
        end
      end else begin
        opb_s = op2_s;
      end
    end else begin
      opa_s = op1_s;
    end
  end

  assign res_s = alu_f(alu_op_s, opa_s, opb_s);

  // Next-state for EX/MEM: bubble beats hold beats load.
  always_comb begin
    exmem_d = exmem_q;
    zero_d  = zero_q;
    if (flush) begin
      exmem_d = 38'd0;
      zero_d  = 1'b0;
    end else if (enable) begin
      exmem_d = exmem_q;
      zero_d  = zero_q;
    end else begin
      exmem_d = {mem_wr_s, res_s, sd_s, wb_en_s, dest_s, wb_sel_s};
      zero_d  = (res_s == 16'h0000);
    end
  end

  // EX/MEM pipeline register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      exmem_q <= 38'd0;
      zero_q  <= 1'b0;
    end else begin
      exmem_q <= exmem_d;
      zero_q  <= zero_d;
    end
  end

  assign exmem_reg_out = exmem_q;
  assign zero_flag     = zero_q;

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 16-bit pipeline.
- Consumes the 63-bit ID/EX pipeline bundle produced by decode.
- Resolves RAW hazards by forwarding from its own EX/MEM register and from the MEM/WB writeback bus, then runs the ALU.
- Registers the result into a 38-bit EX/MEM bundle for the memory stage, with hold (stall) and flush (bubble) control.

Parameters:
FWD_EN, 1, 1 = forwarding muxes active; 0 = raw bundle operands used (debug/bring-up).

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
enable  in  1  hold: when 1 the EX/MEM register keeps its value (same polarity as decode stage)
flush  in  1  load a bubble (all zeros) into EX/MEM on next edge
idex_in  in  63  ID/EX bundle: [62:60] src1, [59:57] src2, [56:54] alu_op, [53:38] op1, [37:22] op2 (imm or reg), [21] mem_wr, [20:5] store_data, [4] wb_en, [3:1] dest, [0] wb_sel (1 = memory result)
wb_en_in  in  1  MEM/WB writeback valid
wb_dest_in  in  3  MEM/WB destination register
wb_data_in  in  16  MEM/WB writeback data
exmem_reg_out  out  38  [37] mem_wr, [36:21] alu_result, [20:5] store_data, [4] wb_en, [3:1] dest, [0] wb_sel
zero_flag  out  1  registered: alu_result == 0 for the instruction in EX/MEM
fwd_sel_1  out  2  combinational debug: 00 none, 01 EX/MEM, 10 MEM/WB for op1
fwd_sel_2  out  2  same, for src2 path

Behaviour:
- Reset: exmem_reg_out = 0, zero_flag = 0.
- Edge priority: rst > flush > enable(hold) > load.
  - flush while enable=1 still writes the bubble.
  - A bubble has wb_en=0 and mem_wr=0.
- Latency: one cycle, idex_in to exmem_reg_out.

Forwarding (FWD_EN=1), evaluated combinationally per src:
- EX/MEM match requires exmem wb_en=1, wb_sel=0, dest==src, src!=0. Data = registered alu_result.
- MEM/WB match requires wb_en_in=1, wb_dest_in==src, src!=0. Data = wb_data_in.
- EX/MEM has priority over MEM/WB when both match.
- EX/MEM entries with wb_sel=1 (load) are never forwarded from; load-use stalls belong to hazard detection.
- Register 0 is never forwarded. A src of 0 means "no register operand".
- src1 match replaces op1.
- src2 match with mem_wr=0 replaces op2.
- src2 match with mem_wr=1 (store) replaces store_data only; op2 stays the immediate offset.
- FWD_EN=0: fwd_sel_* = 00; no substitution.

ALU (16-bit, results truncated, no overflow/carry output):
- 000 ADD a+b
- 001 SUB a-b
- 010 AND
- 011 OR
- 100 XOR
- 101 SLL a << b[3:0]
- 110 SRL a >> b[3:0] (logical)
- 111 PASS b
- Loads and stores use ADD for address generation.
- mem_wr, wb_en, dest and wb_sel pass through unchanged. store_data is post-forwarding.

Other rules:
- zero_flag is updated only when exmem_reg_out loads; it holds with the register on stall and clears on flush/reset.
- Hold cycles: forwarding from EX/MEM still uses the held value. The stalled instruction re-evaluates each cycle, so a MEM/WB value arriving during the stall is picked up.
- Reset mid-stall: rst wins and clears everything.

Test Plan:
1. rst=1 for 2 cycles with arbitrary idex_in -> exmem_reg_out=0, zero_flag=0. Release with ADD op1=5, op2=7, dest=2, wb_en=1 -> next cycle alu_result=12, dest=2, wb_en=1, zero_flag=0.
2. Back-to-back dependency: ADD r2=3+4, then SUB src1=2 with op1 stale 0 and op2=7 -> fwd_sel_1=01, alu_result=0, zero_flag=1. Same sequence with FWD_EN=0 -> alu_result=0xFFF9.
3. Priority: EX/MEM dest=3 result 0x0010 and MEM/WB wb_dest_in=3 data 0x0099 both valid, next op src1=3 -> EX/MEM value used, fwd_sel_1=01.
   - With the EX/MEM entry a load (wb_sel=1) -> MEM/WB 0x0099 used, fwd_sel_1=10.
   - With src1=0 and dest=0 -> no forwarding.
4. Store: mem_wr=1, src2=4, op2=offset 0x0003, op1=0x0100, MEM/WB writes r4=0xBEEF -> alu_result=0x0103, store_data=0xBEEF, op2 not replaced.
5. Stall/flush: enable=1 for 3 cycles -> output frozen while idex_in changes. flush=1 with enable=1 -> output 0, zero_flag=0. flush and rst together -> reset result.
6. Shifts and wrap: SLL 0x8001 by 0x0011 (b[3:0]=1) -> 0x0002. ADD 0xFFFF+1 -> 0x0000, zero_flag=1. PASS op2=0x1234 -> 0x1234.
